cla_chunk_sequencer: RTL
========================

// Module: cla_chunk_sequencer
// PURPOSE
//  Multi-cycle wide adder controller. It feeds WIDTH-bit operands through one CHUNK-bit
//  2-level CLA slice, one chunk per cycle, LSB chunk first.
//  The slice splits each chunk into two CHUNK/2 halves with group P/G and a 2-group
//  lookahead carry; the chunk carry-out is registered into the next chunk.
//  It sits between the array multiplier partial-product stage and the result register,
//  and shares one narrow CLA across a wide final addition. Valid/ready on both sides.
// PARAMETERS
//  WIDTH  32  operand/sum width; must be a multiple of CHUNK
//  CHUNK   8  bits added per cycle; even, >=2; half-group size = CHUNK/2
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operands a,b,cin valid
//  in_ready   out  1      block can accept operands (high only in IDLE)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in to bit 0
//  out_valid  out  1      sum/cout valid (high only in DONE)
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  a+b+cin mod 2^WIDTH, registered
//  cout       out  1      carry out of bit WIDTH-1, registered
//  busy       out  1      high in RUN or DONE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, idx=0, carry reg=0, sum=0, cout=0, out_valid=0;
//   in_ready=1 and busy=0 immediately. Reset mid-RUN/DONE discards the operation.
//  N = WIDTH/CHUNK chunks; idx is a clog2(N)-bit counter (1 bit min when N=1).
//  FSM: IDLE -> RUN on in_valid&in_ready: latch a,b into op regs, carry<=cin, idx<=0.
//   RUN, each cycle: process chunk idx = bits [idx*CHUNK +: CHUNK] with carry-in c0=carry.
//    lo/hi halves: per-bit p=a^b, g=a&b; group P=&p; group G by in-half lookahead.
//    c1 = G0 | (c0&P0) -> carry into hi half; c2 = G1 | (G0&P1) | (c0&P0&P1).
//    sum chunk bits = p ^ internal bit carries; write into sum[idx*CHUNK +: CHUNK].
//    carry<=c2; idx<=idx+1.
//   RUN, idx==N-1: also cout<=c2, idx<=0, -> DONE.
//   DONE: out_valid=1; sum/cout held stable; -> IDLE on out_ready. A result is not
//    dropped while out_ready=0.
//  Latency: operands accepted at edge T; out_valid rises after edge T+N; in_ready
//   returns high the cycle after the output handshake (1 bubble between ops).
//  in_valid while busy is ignored (in_ready=0); a,b,cin only sampled at accept.
//  sum is updated chunk by chunk during RUN. It is only defined while out_valid=1;
//   bits not yet rewritten keep the previous result.
//  Simultaneous out_ready and in_valid in DONE: only the output handshake completes.
//  No overflow flag; the wrap mod 2^WIDTH is reported through cout.
// TESTING (WIDTH=32, CHUNK=8 unless noted)
//  1 a=0x00000001,b=0x00000002,cin=0 -> sum=0x00000003,cout=0; out_valid exactly 4
//    cycles after accept.
//  2 a=0xFFFFFFFF,b=0x00000000,cin=1 -> sum=0x00000000,cout=1 (carry crosses all
//    4 chunk boundaries).
//  3 a=0x80000000,b=0x80000000,cin=0 -> sum=0,cout=1; a=0x0F0F0F0F,b=0xF0F0F0F0,
//    cin=0 -> sum=0xFFFFFFFF,cout=0.
//  4 out_ready=0 for 5 cycles in DONE -> out_valid,sum,cout stable, in_ready=0,
//    in_valid ignored; out_ready=1 -> in_ready=1 next cycle.
//  5 rst_n low after 2 chunks in RUN -> out_valid=0,in_ready=1,sum=0 at once; the
//    next op (case 2) is correct.
//  6 1000 random a,b,cin vs golden a+b+cin, random in_valid/out_ready; repeat with
//    WIDTH=16,CHUNK=4 and WIDTH=8,CHUNK=8 (N=1).

Source files
------------

// File: rtl/cla_chunk_sequencer.sv
// Wide a+b+cin computed one CHUNK-bit slice per cycle through a shared two-half CLA,
// LSB chunk first, with the slice carry-out registered into the next chunk.
module cla_chunk_sequencer #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int N     = WIDTH / CHUNK;
  localparam int HALF  = CHUNK / 2;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic               carry_reg;
  logic [WIDTH-1:0]   a_reg, b_reg, sum_reg;
  logic               cout_reg, in_ready_reg, out_valid_reg, busy_reg;

  logic [CHUNK-1:0]   a_chunk, b_chunk, p, g, chunk_sum;
  logic [1:0]         grp_p, grp_g;
  logic               c1, c2;

  assign a_chunk = a_reg[idx_reg*CHUNK +: CHUNK];
  assign b_chunk = b_reg[idx_reg*CHUNK +: CHUNK];
  assign p       = a_chunk ^ b_chunk;
  assign g       = a_chunk & b_chunk;

  // Two-group lookahead: carry into the hi half and out of the chunk.
  assign c1 = grp_g[0] | (carry_reg & grp_p[0]);
  assign c2 = grp_g[1] | (grp_g[0] & grp_p[1]) | (carry_reg & grp_p[0] & grp_p[1]);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_half
      logic            half_cin, gp, gg;
      logic [HALF-1:0] hsum;

      assign half_cin = (gi == 0) ? carry_reg : c1;
      assign gp       = &p[gi*HALF +: HALF];

      always_comb begin
        logic c;
        gg   = 1'b0;
        hsum = '0;
        c    = half_cin;
        for (int i = 0; i < HALF; i++) begin
          gg      = g[gi*HALF+i] | (p[gi*HALF+i] & gg);
          hsum[i] = p[gi*HALF+i] ^ c;
          c       = g[gi*HALF+i] | (p[gi*HALF+i] & c);
        end
      end

      assign grp_p[gi] = gp;
      assign grp_g[gi] = gg;
      assign chunk_sum[gi*HALF +: HALF] = hsum;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      carry_reg     <= 1'b0;
      a_reg         <= '0;
      b_reg         <= '0;
      sum_reg       <= '0;
      cout_reg      <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg        <= a;
            b_reg        <= b;
            carry_reg    <= cin;
            idx_reg      <= '0;
            state_reg    <= RUN;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
          end
        end
        RUN: begin
          sum_reg[idx_reg*CHUNK +: CHUNK] <= chunk_sum;
          carry_reg <= c2;
          if (idx_reg == IDX_W'(N - 1)) begin
            cout_reg      <= c2;
            idx_reg       <= '0;
            state_reg     <= DONE;
            out_valid_reg <= 1'b1;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        DONE: begin
          // Result is held until the consumer takes it; new operands wait.
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign sum       = sum_reg;
  assign cout      = cout_reg;
  assign busy      = busy_reg;

endmodule
